// File: rtl/recfg_sequencer.sv
// Reconfiguration-trigger sequencer: power-on delay, then armed RECFG pulses.
// Optional abort of a pending trigger is compiled in with `define RECFG_ABORT_EN.
module recfg_sequencer #(
   parameter int unsigned POR_CYCLES   = 33554431,
   parameter int unsigned ARM_CYCLES   = 16,
   parameter int unsigned PULSE_CYCLES = 4,
   parameter bit          AUTO_TRIGGER = 1'b1,
   parameter int unsigned CNT_W        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             abort,
   output logic             por_done,
   output logic             busy,
   output logic             recfg,
   output logic [CNT_W-1:0] trig_count
);

   localparam int unsigned MAX_PA =
      (POR_CYCLES > ARM_CYCLES) ? POR_CYCLES : ARM_CYCLES;
   localparam int unsigned MAX_ALL =
      (MAX_PA > PULSE_CYCLES) ? MAX_PA : PULSE_CYCLES;
   localparam int unsigned CW = $clog2(MAX_ALL + 1);

   // Each phase ends on the edge where cnt is already zero.
   localparam logic [CW-1:0] POR_LD = CW'(POR_CYCLES - 1);
   localparam logic [CW-1:0] ARM_LD = CW'(ARM_CYCLES);
   localparam logic [CW-1:0] PUL_LD =
      CW'((PULSE_CYCLES == 0) ? 0 : PULSE_CYCLES - 1);

   localparam logic [2:0] S_POR   = 3'd0;
   localparam logic [2:0] S_IDLE  = 3'd1;
   localparam logic [2:0] S_ARM   = 3'd2;
   localparam logic [2:0] S_PULSE = 3'd3;
   localparam logic [2:0] S_LATCH = 3'd4;

   logic [2:0]    state;
   logic [2:0]    nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] nxt_cnt;
   logic          abort_hit;
   logic          fire;

`ifdef RECFG_ABORT_EN
   assign abort_hit = abort;
`else
   logic unused_abort;
   assign unused_abort = abort;
   assign abort_hit    = 1'b0;
`endif

   always_comb begin
      nxt = state;
      unique case (state)
         S_POR: begin
            if (cnt == '0)
               nxt = AUTO_TRIGGER ? S_ARM : S_IDLE;
         end
         S_IDLE: begin
            if (req_valid && req_ready)
               nxt = S_ARM;
         end
         S_ARM: begin
            if (abort_hit)
               nxt = S_IDLE;
            else if (cnt == '0)
               nxt = (PULSE_CYCLES == 0) ? S_LATCH : S_PULSE;
         end
         S_PULSE: begin
            if (cnt == '0)
               nxt = S_IDLE;
         end
         S_LATCH: nxt = S_LATCH;
         default: nxt = S_POR;
      endcase
   end

   always_comb begin
      nxt_cnt = cnt;
      if (nxt != state) begin
         unique case (nxt)
            S_ARM:   nxt_cnt = ARM_LD;
            S_PULSE: nxt_cnt = PUL_LD;
            default: nxt_cnt = '0;
         endcase
      end else if (cnt != '0) begin
         nxt_cnt = cnt - 1'b1;
      end
   end

   assign fire = (nxt != state) && (nxt == S_PULSE || nxt == S_LATCH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_POR;
         cnt        <= POR_LD;
         recfg      <= 1'b0;
         req_ready  <= 1'b0;
         busy       <= 1'b1;
         por_done   <= 1'b0;
         trig_count <= '0;
      end else begin
         state     <= nxt;
         cnt       <= nxt_cnt;
         recfg     <= (nxt == S_PULSE) || (nxt == S_LATCH);
         req_ready <= (nxt == S_IDLE);
         busy      <= (nxt != S_IDLE);
         if (state == S_POR && nxt != S_POR)
            por_done <= 1'b1;
         if (fire && trig_count != '1)
            trig_count <= trig_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_recfg_sequencer.sv
// Bench for recfg_sequencer: four configurations checked against an
// event-scheduling model every cycle, plus hand-computed spot values.
module tb_recfg_sequencer;

   logic       clk = 1'b0;
   logic [3:0] rst = '1;
   logic [3:0] rq  = '0;
   logic [3:0] ab  = '0;
   logic [3:0] rr, pd, bz, rf;
   logic [7:0] tc0, tc2, tc3;
   logic [1:0] tc1;

   int checks = 0;
   int errors = 0;
   bit done   = 0;

   always #5 clk = ~clk;

   recfg_sequencer #(.POR_CYCLES(8), .ARM_CYCLES(4), .PULSE_CYCLES(3),
      .AUTO_TRIGGER(1'b1), .CNT_W(8)) u_a (
      .clk(clk), .rst(rst[0]), .req_valid(rq[0]), .req_ready(rr[0]),
      .abort(ab[0]), .por_done(pd[0]), .busy(bz[0]), .recfg(rf[0]),
      .trig_count(tc0));

   recfg_sequencer #(.POR_CYCLES(3), .ARM_CYCLES(0), .PULSE_CYCLES(2),
      .AUTO_TRIGGER(1'b0), .CNT_W(2)) u_b (
      .clk(clk), .rst(rst[1]), .req_valid(rq[1]), .req_ready(rr[1]),
      .abort(ab[1]), .por_done(pd[1]), .busy(bz[1]), .recfg(rf[1]),
      .trig_count(tc1));

   recfg_sequencer #(.POR_CYCLES(5), .ARM_CYCLES(1), .PULSE_CYCLES(0),
      .AUTO_TRIGGER(1'b1), .CNT_W(8)) u_c (
      .clk(clk), .rst(rst[2]), .req_valid(rq[2]), .req_ready(rr[2]),
      .abort(ab[2]), .por_done(pd[2]), .busy(bz[2]), .recfg(rf[2]),
      .trig_count(tc2));

   recfg_sequencer #(.POR_CYCLES(4), .ARM_CYCLES(6), .PULSE_CYCLES(2),
      .AUTO_TRIGGER(1'b0), .CNT_W(8)) u_d (
      .clk(clk), .rst(rst[3]), .req_valid(rq[3]), .req_ready(rr[3]),
      .abort(ab[3]), .por_done(pd[3]), .busy(bz[3]), .recfg(rf[3]),
      .trig_count(tc3));

   int P_POR[4]  = '{8, 3, 5, 4};
   int P_ARM[4]  = '{4, 0, 1, 6};
   int P_PUL[4]  = '{3, 2, 0, 2};
   bit P_AUTO[4] = '{1, 0, 1, 0};
   int P_MAX[4]  = '{255, 3, 255, 255};

`ifdef RECFG_ABORT_EN
   localparam bit ABORT_ON = 1'b1;
`else
   localparam bit ABORT_ON = 1'b0;
`endif

   // Model: edge index since reset release and scheduled rise/fall edges.
   int m_e[4];
   int m_rise[4];
   int m_fall[4];
   int m_acc[4];
   int m_cnt[4];
   bit m_pd[4];
   bit m_idle[4];
   bit m_pul[4];
   bit m_lat[4];

   function automatic int tcv(int i);
      case (i)
         0: return int'(tc0);
         1: return int'(tc1);
         2: return int'(tc2);
         default: return int'(tc3);
      endcase
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic model_step(int i);
      bit idle_pre;
      if (rst[i]) begin
         m_e[i] = 0;    m_rise[i] = -1; m_fall[i] = -1;
         m_acc[i] = -1; m_cnt[i] = 0;   m_pd[i] = 0;
         m_idle[i] = 0; m_pul[i] = 0;   m_lat[i] = 0;
         return;
      end
      m_e[i]++;
      idle_pre = m_idle[i];
      if (ABORT_ON && ab[i] && m_rise[i] >= 0 &&
          m_e[i] > m_acc[i] && m_e[i] <= m_rise[i]) begin
         m_rise[i] = -1;
         m_idle[i] = 1;
         return;
      end
      if (idle_pre && rq[i]) begin
         m_idle[i] = 0;
         m_acc[i]  = m_e[i];
         m_rise[i] = m_e[i] + P_ARM[i] + 1;
      end
      if (m_e[i] == P_POR[i]) begin
         m_pd[i] = 1;
         if (P_AUTO[i]) begin
            m_acc[i]  = m_e[i];
            m_rise[i] = m_e[i] + P_ARM[i] + 1;
         end else begin
            m_idle[i] = 1;
         end
      end
      if (m_e[i] == m_rise[i]) begin
         m_rise[i] = -1;
         if (m_cnt[i] < P_MAX[i]) m_cnt[i]++;
         if (P_PUL[i] == 0) m_lat[i] = 1;
         else begin
            m_pul[i]  = 1;
            m_fall[i] = m_e[i] + P_PUL[i];
         end
      end else if (m_e[i] == m_fall[i]) begin
         m_pul[i]  = 0;
         m_fall[i] = -1;
         m_idle[i] = 1;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         for (int i = 0; i < 4; i++) model_step(i);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!done) begin
            for (int i = 0; i < 4; i++) begin
               chk($sformatf("recfg[%0d]", i), int'(rf[i]),
                   int'(m_pul[i] | m_lat[i]));
               chk($sformatf("req_ready[%0d]", i), int'(rr[i]),
                   int'(m_idle[i]));
               chk($sformatf("busy[%0d]", i), int'(bz[i]),
                   int'(!m_idle[i]));
               chk($sformatf("por_done[%0d]", i), int'(pd[i]),
                   int'(m_pd[i]));
               chk($sformatf("trig_count[%0d]", i), tcv(i), m_cnt[i]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_recfg", int'(rf[0]), 0);
      chk("rst_busy", int'(bz[0]), 1);
      chk("rst_ready", int'(rr[0]), 0);
      chk("rst_pd", int'(pd[0]), 0);
      chk("rst_tc", tcv(0), 0);
      rst = '0;

      // Auto mode: por_done at 8, recfg edges 13..15.
      for (int k = 1; k <= 16; k++) begin
         tick();
         case (k)
            7:  chk("a_pd7", int'(pd[0]), 0);
            8:  begin
               chk("a_pd8", int'(pd[0]), 1);
               chk("a_rf8", int'(rf[0]), 0);
            end
            10: begin
               chk("c_latch10", int'(rf[2]), 1);
               chk("c_ready10", int'(rr[2]), 0);
            end
            12: chk("a_rf12", int'(rf[0]), 0);
            13: chk("a_rf13", int'(rf[0]), 1);
            15: chk("a_rf15", int'(rf[0]), 1);
            16: begin
               chk("a_rf16", int'(rf[0]), 0);
               chk("a_tc16", tcv(0), 1);
               chk("a_rr16", int'(rr[0]), 1);
            end
            default: ;
         endcase
      end

      // Request mode, ARM=0: accept at N, recfg on N+1..N+2.
      rq[1] = 1'b1;
      tick();
      rq[1] = 1'b0;
      chk("b_rr_acc", int'(rr[1]), 0);
      chk("b_rf_acc", int'(rf[1]), 0);
      tick();
      chk("b_rf_n1", int'(rf[1]), 1);
      tick();
      chk("b_rf_n2", int'(rf[1]), 1);
      tick();
      chk("b_rf_n3", int'(rf[1]), 0);
      chk("b_tc1", tcv(1), 1);
      chk("b_rr_n3", int'(rr[1]), 1);

      // Request while pulsing is dropped.
      rq[1] = 1'b1;
      tick();
      rq[1] = 1'b0;
      tick();
      rq[1] = 1'b1;
      tick();
      rq[1] = 1'b0;
      tick();
      tick();
      chk("b_busy_req", tcv(1), 2);
      chk("b_busy_rf", int'(rf[1]), 0);

      // Latched instance ignores requests.
      rq[2] = 1'b1;
      repeat (4) tick();
      chk("c_rr_req", int'(rr[2]), 0);
      chk("c_rf_req", int'(rf[2]), 1);
      rq[2] = 1'b0;

      // Back-to-back pulses every 4 cycles; 2-bit count saturates.
      rq[1] = 1'b1;
      repeat (24) tick();
      chk("b_sat", tcv(1), 3);
      rq[1] = 1'b0;
      repeat (4) tick();
      chk("b_sat_hold", tcv(1), 3);

      // Abort three cycles into ARM.
      rq[3] = 1'b1;
      tick();
      rq[3] = 1'b0;
      tick();
      tick();
      ab[3] = 1'b1;
      tick();
      ab[3] = 1'b0;
      chk("d_abort_rr", int'(rr[3]), ABORT_ON ? 1 : 0);
      repeat (7) tick();
      chk("d_abort_tc", tcv(3), ABORT_ON ? 0 : 1);
      chk("d_abort_rf", int'(rf[3]), 0);

      // Abort on the ARM->PULSE edge.
      rq[3] = 1'b1;
      tick();
      rq[3] = 1'b0;
      repeat (6) tick();
      ab[3] = 1'b1;
      tick();
      ab[3] = 1'b0;
      chk("d_edge_rf", int'(rf[3]), ABORT_ON ? 0 : 1);
      repeat (4) tick();
      chk("d_edge_tc", tcv(3), ABORT_ON ? 0 : 2);

      // Reset while pulsing: recfg drops at once, POR restarts.
      rq[0] = 1'b1;
      tick();
      rq[0] = 1'b0;
      repeat (5) tick();
      chk("a_mid_rf", int'(rf[0]), 1);
      #2 rst[0] = 1'b1;
      #1;
      chk("a_async_rf", int'(rf[0]), 0);
      chk("a_async_bz", int'(bz[0]), 1);
      chk("a_async_pd", int'(pd[0]), 0);
      @(negedge clk);
      tick();
      rst[0] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 7) chk("a_por7", int'(pd[0]), 0);
         if (k == 8) chk("a_por8", int'(pd[0]), 1);
      end

      done = 1;
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
